// File: rtl/merge_4_arb_pkg.sv
// Shared definitions for the 4-way merge/split pair: payload width,
// source-index width, port count and the port-index type.
package merge_4_arb_pkg;

    localparam int DATA_W = 11;
    localparam int CTRL_W = 2;
    localparam int NPORTS = 4;

    typedef logic [CTRL_W-1:0] port_idx_t;

endpackage

// File: rtl/merge_4_arb_if.sv
// Handshake bundle for the 4-way merge: four valid/ready input ports and
// one valid/ready output carrying payload plus source index.
interface merge_4_arb_if #(
    parameter int DATA_W = merge_4_arb_pkg::DATA_W
);
    import merge_4_arb_pkg::*;

    logic [NPORTS-1:0]             in_valid;
    logic [NPORTS-1:0][DATA_W-1:0] in_data;
    logic [NPORTS-1:0]             in_ready;
    logic                          out_valid;
    logic [DATA_W-1:0]             out_data;
    port_idx_t                     out_ctrl;
    logic                          out_ready;

    // Traffic source / sink side
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_ctrl
    );

    // Merge block side
    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_ctrl
    );

endinterface

// File: rtl/merge_4_arb_rr_arb_4.sv
// Round-robin arbiter for four requesters: combinational grant search
// starting at rr_ptr, and a pointer register that only moves when the
// granted request is actually taken.
module rr_arb_4
    import merge_4_arb_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [NPORTS-1:0] req,
    input  logic              take,
    output logic [NPORTS-1:0] gnt,
    output port_idx_t         gnt_idx
);

    port_idx_t rr_ptr;
    port_idx_t idx;
    logic      found;

    // Grant the first requester at or after rr_ptr, wrapping modulo NPORTS
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = '0;
        for (int k = 0; k < NPORTS; k++) begin
            idx = rr_ptr + port_idx_t'(k);
            if (!found && req[idx]) begin
                found        = 1'b1;
                gnt[idx]     = 1'b1;
                gnt_idx      = idx;
            end
        end
    end

    // Move the pointer just past the served port; a grant to port 3 wraps to 0
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr <= '0;
        end else if (take) begin
            rr_ptr <= gnt_idx + port_idx_t'(1);
        end
    end

endmodule

// File: rtl/merge_4_arb.sv
// 4-to-1 round-robin merge with a one-entry output register. The output
// carries the payload and the index of the port it came from, so a
// downstream split can route it back out.
module merge_4_arb #(
    parameter int DATA_W = merge_4_arb_pkg::DATA_W
) (
    input  logic               clk,
    input  logic               reset,
    merge_4_arb_if.slave       bus
);
    import merge_4_arb_pkg::*;

    logic              can_load;
    logic              take;
    logic [NPORTS-1:0] gnt;
    logic [NPORTS-1:0] ready;
    port_idx_t         gnt_idx;

    logic              vld_p0;
    logic [DATA_W-1:0] data_p0;
    port_idx_t         ctrl_p0;

    // The output slot is free when empty or being drained this cycle
    assign can_load = !vld_p0 || bus.out_ready;

    rr_arb_4 u_arb (
        .clk     (clk),
        .reset   (reset),
        .req     (bus.in_valid),
        .take    (take),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    // Accept only from the granted port, never while blocked or in reset
    always_comb begin
        ready = gnt & {NPORTS{can_load && !reset}};
    end

    assign take         = |ready;
    assign bus.in_ready = ready;

    // ---- stage p0: output register (load beats drain, so no bubble) ----
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p0  <= 1'b0;
            data_p0 <= '0;
            ctrl_p0 <= '0;
        end else if (take) begin
            vld_p0  <= 1'b1;
            data_p0 <= bus.in_data[gnt_idx];
            ctrl_p0 <= gnt_idx;
        end else if (bus.out_ready) begin
            vld_p0  <= 1'b0;
        end
    end

    assign bus.out_valid = vld_p0;
    assign bus.out_data  = data_p0;
    assign bus.out_ctrl  = ctrl_p0;

endmodule

// File: tb/tb_merge_4_arb.sv
// Bench for merge_4_arb: directed scenarios plus random traffic, with a
// per-port token scoreboard and a reference model of the arbitration rules.
`timescale 1ns/1ps
module tb_merge_4_arb;
    import merge_4_arb_pkg::*;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    merge_4_arb_if #(.DATA_W(DATA_W)) bus ();

    merge_4_arb #(.DATA_W(DATA_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    // Per-port scoreboard of issued tokens, in issue order
    logic [DATA_W-1:0] exp_q [NPORTS][$];

    // Reference model state
    logic              chk_en = 1'b0;
    logic              m_full = 1'b0;
    int                m_ptr  = 0;
    int                m_ctrl = 0;
    logic [DATA_W-1:0] m_data = '0;
    logic [NPORTS-1:0] exp_rdy;
    int                g_m;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model + scoreboard, sampled at the falling edge
    always @(negedge clk) begin
        if (chk_en) begin
            check("out_valid", 32'(bus.out_valid), 32'(m_full));
            if (m_full) begin
                check("out_data", 32'(bus.out_data), 32'(m_data));
                check("out_ctrl", 32'(bus.out_ctrl), 32'(m_ctrl));
            end

            exp_rdy = '0;
            g_m     = -1;
            if (!reset && (!m_full || bus.out_ready)) begin
                for (int k = 0; k < NPORTS; k++) begin
                    if (g_m < 0 && bus.in_valid[(m_ptr + k) % NPORTS])
                        g_m = (m_ptr + k) % NPORTS;
                end
            end
            if (g_m >= 0) exp_rdy[g_m] = 1'b1;
            check("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
            check("in_ready_onehot0", 32'($onehot0(bus.in_ready)), 32'd1);

            if (!reset && bus.out_valid === 1'b1 && bus.out_ready) begin
                if (exp_q[bus.out_ctrl].size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL sb_unexpected: got port %0d data %0h expected no token", bus.out_ctrl, bus.out_data);
                end else begin
                    check("sb_port_order", 32'(bus.out_data), 32'(exp_q[bus.out_ctrl].pop_front()));
                end
            end

            if (reset) begin
                m_full = 1'b0;
                m_ptr  = 0;
                m_ctrl = 0;
                m_data = '0;
            end else if (g_m >= 0) begin
                m_full = 1'b1;
                m_data = bus.in_data[g_m];
                m_ctrl = g_m;
                m_ptr  = (g_m + 1) % NPORTS;
            end else if (m_full && bus.out_ready) begin
                m_full = 1'b0;
            end
        end
    end

    // One clock: drop valids that were accepted, end 2 ns after the edge
    task automatic tick();
        logic [NPORTS-1:0] acc;
        @(negedge clk);
        acc = bus.in_valid & bus.in_ready;
        @(posedge clk);
        #1;
        bus.in_valid = bus.in_valid & ~acc;
        #1;
    endtask

    task automatic offer(input int p, input logic [DATA_W-1:0] d);
        bus.in_valid[p] = 1'b1;
        bus.in_data[p]  = d;
        exp_q[p].push_back(d);
    endtask

    int   issued [NPORTS];
    logic seen7ff;

    initial begin
        bus.in_valid  = '0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        reset         = 1'b1;
        tick();
        chk_en = 1'b1;
        tick();

        // Reset state, and no acceptance while reset is high
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_data",  32'(bus.out_data),  32'd0);
        check("rst_out_ctrl",  32'(bus.out_ctrl),  32'd0);
        bus.in_valid  = '1;
        bus.out_ready = 1'b1;
        #1;
        check("rst_in_ready", 32'(bus.in_ready), 32'd0);
        tick();
        bus.in_valid = '0;
        reset        = 1'b0;

        // Single request on port 2
        offer(2, 11'h155);
        #1;
        check("t1_in_ready", 32'(bus.in_ready), 32'b0100);
        tick();
        check("t1_out_valid", 32'(bus.out_valid), 32'd1);
        check("t1_out_data",  32'(bus.out_data),  32'h155);
        check("t1_out_ctrl",  32'(bus.out_ctrl),  32'd2);
        tick();
        check("t1_drained", 32'(bus.out_valid), 32'd0);

        // Pointer now at 3: ports 3 and 0 requesting -> 3 then 0
        offer(0, 11'h0A0);
        offer(3, 11'h3A3);
        #1;
        check("wrap_first_gnt", 32'(bus.in_ready), 32'b1000);
        tick();
        check("wrap_ctrl3", 32'(bus.out_ctrl), 32'd3);
        check("wrap_data3", 32'(bus.out_data), 32'h3A3);
        check("wrap_next_gnt", 32'(bus.in_ready), 32'b0001);
        tick();
        check("wrap_ctrl0", 32'(bus.out_ctrl), 32'd0);
        check("wrap_data0", 32'(bus.out_data), 32'h0A0);
        tick();

        // All four ports requesting, four tokens each
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int p = 0; p < NPORTS; p++) begin
            offer(p, 11'(32'h100 + p));
            issued[p] = 1;
        end
        for (int n = 0; n < 16; n++) begin
            tick();
            check("rr_valid", 32'(bus.out_valid), 32'd1);
            check("rr_ctrl",  32'(bus.out_ctrl),  32'(n % 4));
            check("rr_data",  32'(bus.out_data),  32'h100 + 32'(n % 4));
            for (int p = 0; p < NPORTS; p++) begin
                if (!bus.in_valid[p] && issued[p] < 4) begin
                    offer(p, 11'(32'h100 + p));
                    issued[p]++;
                end
            end
        end
        tick();

        // Output full and blocked for 5 cycles
        bus.out_ready = 1'b0;
        offer(2, 11'h222);
        tick();
        check("blk_full_ctrl", 32'(bus.out_ctrl), 32'd2);
        offer(0, 11'h011);
        offer(1, 11'h111);
        for (int i = 0; i < 5; i++) begin
            #1;
            check("blk_in_ready", 32'(bus.in_ready), 32'd0);
            check("blk_hold",     32'(bus.out_data), 32'h222);
            tick();
        end
        bus.out_ready = 1'b1;
        #1;
        check("blk_release_gnt", 32'(bus.in_ready), 32'b0001);
        tick();
        check("blk_ctrl0", 32'(bus.out_ctrl), 32'd0);
        check("blk_data0", 32'(bus.out_data), 32'h011);
        check("blk_next_gnt", 32'(bus.in_ready), 32'b0010);
        tick();
        check("blk_ctrl1", 32'(bus.out_ctrl), 32'd1);
        check("blk_data1", 32'(bus.out_data), 32'h111);
        tick();

        // Reset while a token sits in the output register
        bus.out_ready = 1'b0;
        offer(0, 11'h7FF);
        tick();
        check("rst_hold_valid", 32'(bus.out_valid), 32'd1);
        check("rst_hold_data",  32'(bus.out_data),  32'h7FF);
        reset = 1'b1;
        offer(1, 11'h0AB);
        #1;
        check("rst_no_accept", 32'(bus.in_ready), 32'd0);
        tick();
        reset = 1'b0;
        check("rst_flush_valid", 32'(bus.out_valid), 32'd0);
        check("rst_flush_data",  32'(bus.out_data),  32'd0);
        exp_q[0].delete();
        bus.out_ready = 1'b1;
        seen7ff = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (i == 0) begin
                check("rst_first_ctrl", 32'(bus.out_ctrl), 32'd1);
                check("rst_first_data", 32'(bus.out_data), 32'h0AB);
            end
            if (bus.out_valid && bus.out_data == 11'h7FF) seen7ff = 1'b1;
        end
        check("rst_no_7ff", 32'(seen7ff), 32'd0);

        // Random traffic
        for (int c = 0; c < 10000; c++) begin
            for (int p = 0; p < NPORTS; p++) begin
                if (!bus.in_valid[p] && $urandom_range(0, 1) == 1)
                    offer(p, 11'($urandom_range(0, 2047)));
            end
            bus.out_ready = ($urandom_range(0, 9) < 7);
            tick();
        end

        // Drain everything still in flight
        bus.out_ready = 1'b1;
        for (int i = 0; i < 100 && (bus.in_valid != '0 || bus.out_valid); i++) tick();
        check("drain_done", {30'd0, bus.in_valid != '0, bus.out_valid}, 32'd0);
        for (int p = 0; p < NPORTS; p++)
            check("sb_leftover", 32'(exp_q[p].size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
